// File: rtl/uart_frame_controller.sv
// rtl/uart_frame_controller.sv - frames UART bytes into checked register-write bursts
// Sync/addr/len/payload/xor frames are buffered, then replayed to the write port.
module uart_frame_controller #(
   parameter int CLK_FREQUENCY  = 100000000,
   parameter int BAUD_RATE      = 57600,
   parameter int TIMEOUT_BYTES  = 4,
   parameter int MAX_LEN        = 16,
   parameter int ADDR_WIDTH     = 8,
   parameter int TIMEOUT_CYCLES = CLK_FREQUENCY / BAUD_RATE * 10 * TIMEOUT_BYTES
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  rx_valid,
   input  logic [7:0]            rx_data,
   output logic                  wr_en,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [7:0]            wr_data,
   input  logic                  wr_ready,
   output logic                  busy,
   output logic                  frame_done,
   output logic                  frame_err,
   output logic [1:0]            err_code,
   output logic                  rx_drop
);

   localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   // frame_err is registered, so the limit is detected one cycle early; needs TIMEOUT_CYCLES >= 2
   localparam logic [TW-1:0] GAP_LAST  = TW'(TIMEOUT_CYCLES - 2);
   localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);

   typedef enum logic [2:0] {
      ST_IDLE, ST_ADDR, ST_LEN, ST_PAYLOAD, ST_CHECK, ST_COMMIT
   } state_t;

   state_t                state, state_nx;
   logic [7:0]            chk_xor;
   logic [7:0]            frame_len;
   logic [7:0]            wr_idx;
   logic [7:0]            issue_idx;
   logic [7:0]            acc_cnt;
   logic [ADDR_WIDTH-1:0] start_addr;
   logic [TW-1:0]         gap_cnt;
   logic [7:0]            buf_mem [0:(1<<IW)-1];

   logic                  in_frame;
   logic                  accept;
   logic                  load_wr;
   logic                  last_accept;
   logic                  err_set;
   logic [1:0]            err_nx;

   assign busy     = (state != ST_IDLE);
   assign in_frame = (state == ST_ADDR) || (state == ST_LEN) ||
                     (state == ST_PAYLOAD) || (state == ST_CHECK);
   assign accept   = wr_en && wr_ready;

   always_comb begin
      state_nx    = state;
      err_set     = 1'b0;
      err_nx      = 2'd0;
      load_wr     = 1'b0;
      last_accept = 1'b0;
      case (state)
         ST_IDLE: begin
            if (rx_valid && rx_data == 8'hA5) state_nx = ST_ADDR;
         end
         ST_ADDR: begin
            if (rx_valid) state_nx = ST_LEN;
         end
         ST_LEN: begin
            if (rx_valid) begin
               if (rx_data == 8'd0 || rx_data > MAX_LEN_B) begin
                  state_nx = ST_IDLE;
                  err_set  = 1'b1;
                  err_nx   = 2'd1;
               end else begin
                  state_nx = ST_PAYLOAD;
               end
            end
         end
         ST_PAYLOAD: begin
            if (rx_valid && wr_idx == frame_len - 8'd1) state_nx = ST_CHECK;
         end
         ST_CHECK: begin
            if (rx_valid) begin
               if (rx_data == chk_xor) begin
                  state_nx = ST_COMMIT;
               end else begin
                  state_nx = ST_IDLE;
                  err_set  = 1'b1;
                  err_nx   = 2'd2;
               end
            end
         end
         ST_COMMIT: begin
            // refill the write register whenever it is empty or being drained
            load_wr     = (!wr_en || accept) && (issue_idx != frame_len);
            last_accept = accept && (acc_cnt == frame_len - 8'd1);
            if (last_accept) state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
      if (in_frame && !rx_valid && gap_cnt == GAP_LAST) begin
         state_nx = ST_IDLE;
         err_set  = 1'b1;
         err_nx   = 2'd3;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         chk_xor    <= 8'd0;
         frame_len  <= 8'd0;
         wr_idx     <= 8'd0;
         issue_idx  <= 8'd0;
         acc_cnt    <= 8'd0;
         start_addr <= '0;
         gap_cnt    <= '0;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= 8'd0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
         err_code   <= 2'd0;
         rx_drop    <= 1'b0;
      end else begin
         state      <= state_nx;
         frame_err  <= err_set;
         frame_done <= last_accept;
         rx_drop    <= (state == ST_COMMIT) && rx_valid;
         if (err_set) err_code <= err_nx;

         if (in_frame && !rx_valid) gap_cnt <= gap_cnt + TW'(1);
         else                       gap_cnt <= '0;

         case (state)
            ST_IDLE: chk_xor <= 8'd0;
            ST_ADDR: begin
               if (rx_valid) begin
                  start_addr <= rx_data[ADDR_WIDTH-1:0];
                  chk_xor    <= chk_xor ^ rx_data;
               end
            end
            ST_LEN: begin
               if (rx_valid) begin
                  chk_xor   <= chk_xor ^ rx_data;
                  frame_len <= rx_data;
                  wr_idx    <= 8'd0;
               end
            end
            ST_PAYLOAD: begin
               if (rx_valid) begin
                  chk_xor <= chk_xor ^ rx_data;
                  wr_idx  <= wr_idx + 8'd1;
               end
            end
            ST_CHECK: begin
               if (rx_valid) begin
                  issue_idx <= 8'd0;
                  acc_cnt   <= 8'd0;
               end
            end
            ST_COMMIT: begin
               if (load_wr) begin
                  wr_en     <= 1'b1;
                  wr_data   <= buf_mem[issue_idx[IW-1:0]];
                  wr_addr   <= start_addr + issue_idx[ADDR_WIDTH-1:0];
                  issue_idx <= issue_idx + 8'd1;
               end else if (accept) begin
                  wr_en <= 1'b0;
               end
               if (accept) acc_cnt <= acc_cnt + 8'd1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (state == ST_PAYLOAD && rx_valid) buf_mem[wr_idx[IW-1:0]] <= rx_data;
   end

endmodule

// File: tb/tb_uart_frame_controller.sv
// tb/tb_uart_frame_controller.sv - directed self-checking bench for uart_frame_controller
// Inputs change and outputs are sampled 1ns after the rising edge; a monitor logs writes on the falling edge.
module tb_uart_frame_controller;
   localparam int TO = 40;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx_valid = 1'b0;
   logic [7:0] rx_data = 8'd0;
   logic       wr_ready = 1'b1;
   logic       wr_en;
   logic [7:0] wr_addr;
   logic [7:0] wr_data;
   logic       busy;
   logic       frame_done;
   logic       frame_err;
   logic [1:0] err_code;
   logic       rx_drop;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   uart_frame_controller #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
      .busy(busy), .frame_done(frame_done), .frame_err(frame_err),
      .err_code(err_code), .rx_drop(rx_drop)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int done_cnt = 0, err_cnt = 0, drop_cnt = 0, wen_cnt = 0, err_cyc = -1, done_cyc = -1;
   logic [1:0] last_code = 2'd0;
   logic [7:0] wq_addr[$];
   logic [7:0] wq_data[$];
   int         wq_cyc[$];

   always @(negedge clk) begin
      if (wr_en) wen_cnt++;
      if (wr_en && wr_ready) begin
         wq_addr.push_back(wr_addr);
         wq_data.push_back(wr_data);
         wq_cyc.push_back(cyc);
      end
      if (frame_done) begin done_cnt++; done_cyc = cyc; end
      if (frame_err) begin err_cnt++; err_cyc = cyc; last_code = err_code; end
      if (rx_drop) drop_cnt++;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_data  = b;
      step();
      rx_valid = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) step();
      n_cmp++;
      if ({wr_en, busy, frame_done, frame_err, rx_drop, err_code, wr_addr, wr_data} !== 23'd0) begin
         n_bad++;
         $display("FAIL reset_outputs: got %h expected 0",
                  {wr_en, busy, frame_done, frame_err, rx_drop, err_code, wr_addr, wr_data});
      end
      rst_n = 1'b1;
      step();
      n_cmp++;
      if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
   endtask

   task automatic test_good_frame();
      logic [7:0] ea[3] = '{8'h10, 8'h11, 8'h12};
      logic [7:0] ed[3] = '{8'h11, 8'h22, 8'h33};
      logic [7:0] fr[7] = '{8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h13};
      int bw = wq_addr.size(), bd = done_cnt, be = err_cnt, c0 = cyc;
      for (int i = 0; i < 7; i++) send(fr[i]);
      repeat (8) step();
      n_cmp++;
      if (wq_addr.size() - bw !== 3) begin n_bad++; $display("FAIL good_nwrites: got %0d expected 3", wq_addr.size() - bw); end
      for (int i = 0; i < 3; i++) begin
         if (wq_addr.size() > bw + i) begin
            n_cmp++;
            if ({wq_addr[bw+i], wq_data[bw+i]} !== {ea[i], ed[i]}) begin
               n_bad++;
               $display("FAIL good_write%0d: got %h/%h expected %h/%h", i, wq_addr[bw+i], wq_data[bw+i], ea[i], ed[i]);
            end
            n_cmp++;
            if (wq_cyc[bw+i] !== c0 + 8 + i) begin
               n_bad++;
               $display("FAIL good_write%0d_cycle: got %0d expected %0d", i, wq_cyc[bw+i] - c0, 8 + i);
            end
         end
      end
      n_cmp++;
      if (done_cnt - bd !== 1) begin n_bad++; $display("FAIL good_done_count: got %0d expected 1", done_cnt - bd); end
      n_cmp++;
      if (done_cyc !== c0 + 11) begin n_bad++; $display("FAIL good_done_cycle: got %0d expected 11", done_cyc - c0); end
      n_cmp++;
      if (err_cnt - be !== 0) begin n_bad++; $display("FAIL good_no_err: got %0d expected 0", err_cnt - be); end
      n_cmp++;
      if (busy !== 1'b0) begin n_bad++; $display("FAIL good_busy_after: got %b expected 0", busy); end
   endtask

   task automatic test_bad_checksum();
      logic [7:0] fr[7] = '{8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h14};
      int bwen = wen_cnt, be = err_cnt, c0 = cyc;
      for (int i = 0; i < 7; i++) send(fr[i]);
      repeat (5) step();
      n_cmp++;
      if (err_cnt - be !== 1) begin n_bad++; $display("FAIL badchk_err_count: got %0d expected 1", err_cnt - be); end
      n_cmp++;
      if (err_cyc !== c0 + 7) begin n_bad++; $display("FAIL badchk_err_cycle: got %0d expected 7", err_cyc - c0); end
      n_cmp++;
      if (last_code !== 2'd2) begin n_bad++; $display("FAIL badchk_code: got %0d expected 2", last_code); end
      n_cmp++;
      if (err_code !== 2'd2) begin n_bad++; $display("FAIL badchk_code_held: got %0d expected 2", err_code); end
      n_cmp++;
      if (wen_cnt - bwen !== 0) begin n_bad++; $display("FAIL badchk_no_writes: got %0d expected 0", wen_cnt - bwen); end
      n_cmp++;
      if (busy !== 1'b0) begin n_bad++; $display("FAIL badchk_busy: got %b expected 0", busy); end
   endtask

   task automatic test_bad_length();
      logic [7:0] lens[2] = '{8'h00, 8'h11};
      logic [7:0] fr[5] = '{8'hA5, 8'h20, 8'h01, 8'h55, 8'h74};
      int bwen, bw, bd, be, c0;
      for (int k = 0; k < 2; k++) begin
         be = err_cnt;
         bwen = wen_cnt;
         c0 = cyc;
         send(8'hA5); send(8'h10); send(lens[k]);
         repeat (3) step();
         n_cmp++;
         if (err_cnt - be !== 1 || err_cyc !== c0 + 3) begin
            n_bad++;
            $display("FAIL badlen%0d_err: got count %0d at +%0d expected 1 at +3", k, err_cnt - be, err_cyc - c0);
         end
         n_cmp++;
         if (last_code !== 2'd1) begin n_bad++; $display("FAIL badlen%0d_code: got %0d expected 1", k, last_code); end
         n_cmp++;
         if (wen_cnt - bwen !== 0) begin n_bad++; $display("FAIL badlen%0d_no_writes: got %0d expected 0", k, wen_cnt - bwen); end
      end
      bw = wq_addr.size();
      bd = done_cnt;
      c0 = cyc;
      for (int i = 0; i < 5; i++) send(fr[i]);
      repeat (6) step();
      n_cmp++;
      if (wq_addr.size() - bw !== 1) begin
         n_bad++;
         $display("FAIL badlen_recover_nwrites: got %0d expected 1", wq_addr.size() - bw);
      end else begin
         n_cmp++;
         if ({wq_addr[bw], wq_data[bw], wq_cyc[bw] - c0} !== {8'h20, 8'h55, 32'd6}) begin
            n_bad++;
            $display("FAIL badlen_recover_write: got %h/%h at +%0d expected 20/55 at +6", wq_addr[bw], wq_data[bw], wq_cyc[bw] - c0);
         end
      end
      n_cmp++;
      if (done_cnt - bd !== 1) begin n_bad++; $display("FAIL badlen_recover_done: got %0d expected 1", done_cnt - bd); end
   endtask

   task automatic test_addr_wrap();
      logic [7:0] fr[6] = '{8'hA5, 8'hFF, 8'h02, 8'hAA, 8'hBB, 8'hEC};
      int bw = wq_addr.size(), c0 = cyc;
      for (int i = 0; i < 6; i++) send(fr[i]);
      repeat (6) step();
      n_cmp++;
      if (wq_addr.size() - bw !== 2) begin
         n_bad++;
         $display("FAIL wrap_nwrites: got %0d expected 2", wq_addr.size() - bw);
      end else begin
         n_cmp++;
         if ({wq_addr[bw], wq_data[bw], wq_addr[bw+1], wq_data[bw+1]} !== 32'hFFAA00BB) begin
            n_bad++;
            $display("FAIL wrap_writes: got %h/%h %h/%h expected FF/AA 00/BB", wq_addr[bw], wq_data[bw], wq_addr[bw+1], wq_data[bw+1]);
         end
         n_cmp++;
         if (wq_cyc[bw+1] - wq_cyc[bw] !== 1) begin
            n_bad++;
            $display("FAIL wrap_back_to_back: got gap %0d expected 1", wq_cyc[bw+1] - wq_cyc[bw]);
         end
      end
   endtask

   task automatic test_timeout();
      logic [7:0] rest[4] = '{8'h11, 8'h22, 8'h33, 8'h13};
      int be = err_cnt, bw, bd, t;
      send(8'hA5);
      t = cyc;
      send(8'h10);
      repeat (TO + 5) step();
      n_cmp++;
      if (err_cnt - be !== 1) begin n_bad++; $display("FAIL timeout_err_count: got %0d expected 1", err_cnt - be); end
      n_cmp++;
      if (err_cyc !== t + TO) begin n_bad++; $display("FAIL timeout_err_cycle: got %0d expected %0d", err_cyc - t, TO); end
      n_cmp++;
      if (last_code !== 2'd3) begin n_bad++; $display("FAIL timeout_code: got %0d expected 3", last_code); end
      n_cmp++;
      if (busy !== 1'b0) begin n_bad++; $display("FAIL timeout_busy: got %b expected 0", busy); end
      be = err_cnt;
      bw = wq_addr.size();
      bd = done_cnt;
      send(8'hA5);
      t = cyc;
      send(8'h10);
      repeat (TO - 2) step();
      send(8'h03);
      for (int i = 0; i < 4; i++) send(rest[i]);
      repeat (8) step();
      n_cmp++;
      if (err_cnt - be !== 0) begin n_bad++; $display("FAIL timeout_edge_no_err: got %0d expected 0", err_cnt - be); end
      n_cmp++;
      if (wq_addr.size() - bw !== 3 || done_cnt - bd !== 1) begin
         n_bad++;
         $display("FAIL timeout_edge_commit: got %0d writes %0d done expected 3 writes 1 done", wq_addr.size() - bw, done_cnt - bd);
      end else begin
         n_cmp++;
         if ({wq_addr[bw+2], wq_data[bw+2]} !== 16'h1233) begin
            n_bad++;
            $display("FAIL timeout_edge_last_write: got %h/%h expected 12/33", wq_addr[bw+2], wq_data[bw+2]);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] fr[7] = '{8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h13};
      logic       rp[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      int         ec[3] = '{8, 11, 12};
      int bw = wq_addr.size(), bd = done_cnt, c0 = cyc;
      for (int i = 0; i < 7; i++) send(fr[i]);
      step();
      for (int j = 0; j < 6; j++) begin
         wr_ready = rp[j];
         if (j == 1 || j == 2) begin
            n_cmp++;
            if ({wr_en, wr_addr, wr_data} !== 17'h11122) begin
               n_bad++;
               $display("FAIL bp_stall%0d_hold: got en=%b %h/%h expected en=1 11/22", j, wr_en, wr_addr, wr_data);
            end
         end
         step();
      end
      wr_ready = 1'b1;
      repeat (2) step();
      n_cmp++;
      if (wq_addr.size() - bw !== 3) begin
         n_bad++;
         $display("FAIL bp_nwrites: got %0d expected 3", wq_addr.size() - bw);
      end else begin
         for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if ({wq_addr[bw+i], wq_data[bw+i]} !== {8'h10 + 8'(i), 8'h11 * 8'(i + 1)} || wq_cyc[bw+i] - c0 !== ec[i]) begin
               n_bad++;
               $display("FAIL bp_write%0d: got %h/%h at +%0d expected %h/%h at +%0d", i, wq_addr[bw+i], wq_data[bw+i],
                        wq_cyc[bw+i] - c0, 8'h10 + 8'(i), 8'h11 * 8'(i + 1), ec[i]);
            end
         end
      end
      n_cmp++;
      if (done_cnt - bd !== 1 || done_cyc !== c0 + 13) begin
         n_bad++;
         $display("FAIL bp_done: got %0d at +%0d expected 1 at +13", done_cnt - bd, done_cyc - c0);
      end
   endtask

   task automatic test_drop();
      logic [7:0] fr[6] = '{8'hA5, 8'h30, 8'h02, 8'h01, 8'h02, 8'h31};
      int bw = wq_addr.size(), bd = done_cnt, be = err_cnt, bdr = drop_cnt;
      wr_ready = 1'b0;
      for (int i = 0; i < 6; i++) send(fr[i]);
      repeat (3) send(8'hA5);
      wr_ready = 1'b1;
      repeat (4) step();
      n_cmp++;
      if (drop_cnt - bdr !== 3) begin n_bad++; $display("FAIL drop_count: got %0d expected 3", drop_cnt - bdr); end
      n_cmp++;
      if (wq_addr.size() - bw !== 2) begin
         n_bad++;
         $display("FAIL drop_nwrites: got %0d expected 2", wq_addr.size() - bw);
      end else begin
         n_cmp++;
         if ({wq_addr[bw], wq_data[bw], wq_addr[bw+1], wq_data[bw+1]} !== 32'h30013102) begin
            n_bad++;
            $display("FAIL drop_writes: got %h/%h %h/%h expected 30/01 31/02", wq_addr[bw], wq_data[bw], wq_addr[bw+1], wq_data[bw+1]);
         end
      end
      n_cmp++;
      if (done_cnt - bd !== 1) begin n_bad++; $display("FAIL drop_done: got %0d expected 1", done_cnt - bd); end
      repeat (TO + 5) step();
      n_cmp++;
      if (busy !== 1'b0 || err_cnt - be !== 0) begin
         n_bad++;
         $display("FAIL drop_no_new_frame: got busy=%b errs=%0d expected busy=0 errs=0", busy, err_cnt - be);
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] fr[5] = '{8'hA5, 8'h40, 8'h04, 8'h01, 8'h02};
      logic [7:0] gd[5] = '{8'hA5, 8'h50, 8'h01, 8'h77, 8'h26};
      int bw = wq_addr.size(), bd = done_cnt, be = err_cnt, bwen = wen_cnt;
      for (int i = 0; i < 5; i++) send(fr[i]);
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({wr_en, busy, frame_done, frame_err, rx_drop, err_code, wr_addr, wr_data} !== 23'd0) begin
         n_bad++;
         $display("FAIL rstmid_outputs: got %h expected 0",
                  {wr_en, busy, frame_done, frame_err, rx_drop, err_code, wr_addr, wr_data});
      end
      step();
      rst_n = 1'b1;
      repeat (TO + 5) step();
      n_cmp++;
      if (wen_cnt - bwen !== 0 || done_cnt - bd !== 0 || err_cnt - be !== 0) begin
         n_bad++;
         $display("FAIL rstmid_quiet: got wen=%0d done=%0d err=%0d expected 0/0/0", wen_cnt - bwen, done_cnt - bd, err_cnt - be);
      end
      for (int i = 0; i < 5; i++) send(gd[i]);
      repeat (6) step();
      n_cmp++;
      if (wq_addr.size() - bw !== 1) begin
         n_bad++;
         $display("FAIL rstmid_next_nwrites: got %0d expected 1", wq_addr.size() - bw);
      end else begin
         n_cmp++;
         if ({wq_addr[bw], wq_data[bw]} !== 16'h5077) begin
            n_bad++;
            $display("FAIL rstmid_next_write: got %h/%h expected 50/77", wq_addr[bw], wq_data[bw]);
         end
      end
      n_cmp++;
      if (done_cnt - bd !== 1) begin n_bad++; $display("FAIL rstmid_next_done: got %0d expected 1", done_cnt - bd); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_good_frame();
      test_bad_checksum();
      test_bad_length();
      test_addr_wrap();
      test_timeout();
      test_backpressure();
      test_drop();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/uart_frame_controller.md
# uart_frame_controller

Sequences the byte stream produced by the UART receiver into framed register-write transactions. Accepts one-cycle byte strobes, validates the frame (sync, length, XOR checksum, inter-byte timeout), and buffers the payload internally. It then commits the payload as a burst of writes to a downstream register/memory port with a valid/ready handshake. Sits between the UART receiver and the on-chip register file.

## Interface

- Reset: one clock; reset is asynchronous and active-low.
- Parameters:
  - `CLK_FREQUENCY`, default 100000000: clock rate in Hz.
  - `BAUD_RATE`, default 57600: line rate; used only for the timeout.
  - `TIMEOUT_BYTES`, default 4: inter-byte gap limit, in 10-bit character times.
  - `MAX_LEN`, default 16: maximum payload bytes per frame, 1..255.
  - `ADDR_WIDTH`, default 8: write address width, ≤ 8.
  - `TIMEOUT_CYCLES`, default CLK_FREQUENCY/BAUD_RATE*10*TIMEOUT_BYTES: derived.
- Ports:
  - `clk`  in  1  clock.
  - `rst_n`  in  1  asynchronous active-low reset.
  - `rx_valid`  in  1  one-cycle strobe: `rx_data` holds a received byte.
  - `rx_data`  in  8  received byte.
  - `wr_en`  out  1  write request.
  - `wr_addr`  out  ADDR_WIDTH  write address.
  - `wr_data`  out  8  write data.
  - `wr_ready`  in  1  sink accepts the write in any cycle where `wr_en && wr_ready`.
  - `busy`  out  1  high in every state except IDLE.
  - `frame_done`  out  1  one-cycle pulse: frame fully committed.
  - `frame_err`  out  1  one-cycle pulse: frame rejected.
  - `err_code`  out  2  valid with `frame_err`, held until the next error. 1 = bad length, 2 = checksum mismatch, 3 = timeout.
  - `rx_drop`  out  1  one-cycle pulse: byte discarded during COMMIT.

## Operation

- Frame format: `0xA5`, ADDR, LEN, LEN payload bytes, CHK. CHK = XOR of ADDR, LEN and all payload bytes.
- States: IDLE, ADDR, LEN, PAYLOAD, CHECK, COMMIT.
- **IDLE**
  - On `rx_valid` with `0xA5`: go to ADDR and clear the running XOR.
  - On any other byte: ignore silently, no error.
- **ADDR:** on a byte, latch the start address (low ADDR_WIDTH bits), XOR the byte in, go to LEN.
- **LEN:** on a byte, XOR it in.
  - If 0 or > MAX_LEN: pulse `frame_err` with code 1 and return to IDLE.
  - Otherwise latch LEN, clear the payload index, go to PAYLOAD.
- **PAYLOAD:**
  - Each byte is written to internal buffer[index], XORed in, and the index increments.
  - After the LEN-th byte, go to CHECK.
- **CHECK:** on a byte, compare it with the running XOR.
  - Match: go to COMMIT with read index 0.
  - Mismatch: pulse `frame_err` with code 2, go to IDLE, issue no writes.
- **COMMIT:**
  - Present buffer[i] at address start + i, with address wrap-around modulo 2^ADDR_WIDTH.
  - Advance i on each accepted write.
  - After the LEN-th acceptance: pulse `frame_done` and go to IDLE.
  - Any `rx_valid` in COMMIT is discarded and pulses `rx_drop`. A `0xA5` received here does not start a frame.
- **Timeout:**
  - In ADDR, LEN, PAYLOAD and CHECK, a gap counter counts cycles since the last accepted byte.
  - When it reaches TIMEOUT_CYCLES: pulse `frame_err` with code 3, go to IDLE.
  - The counter is cleared on every accepted byte and in IDLE/COMMIT.
  - If `rx_valid` coincides with the timeout cycle, the byte wins: it is processed and the counter clears.
- **Write port:** `wr_addr`/`wr_data` stay stable while `wr_en` is high and `wr_ready` is low. `wr_en` never drops before acceptance.

## Timing

- Reset values: `wr_en`, `busy`, `frame_done`, `frame_err`, `rx_drop` = 0. `err_code`, `wr_addr`, `wr_data` = 0. State = IDLE.
- Buffer contents are not reset.
- `rst_n` asserted mid-frame or mid-COMMIT aborts immediately:
  - No further writes.
  - No done or error pulse.
- Each byte is consumed in its `rx_valid` cycle; state updates on that edge. No input stall is possible.
- `frame_err` for length/checksum asserts in the cycle after the offending `rx_valid`.
- First `wr_en` asserts two cycles after the CHK `rx_valid`: one cycle for the CHECK transition, one for the registered buffer read.
- With `wr_ready` held high: one write per cycle, back-to-back.
- `frame_done` asserts in the cycle after the final accepted write.
- `busy` falls in that same cycle.

## Test plan

- **Good frame:** A5 10 03 11 22 33 13 → writes (0x10,0x11), (0x11,0x22), (0x12,0x33) in consecutive cycles; one `frame_done`; no `frame_err`.
- **Bad checksum:** A5 10 03 11 22 33 14 → `frame_err` with `err_code`=2, zero `wr_en` cycles, `busy` low afterwards.
- **Bad length:** A5 10 00 → `frame_err` code 1 one cycle after the LEN byte. Also repeat with LEN = MAX_LEN+1 → code 1. The following valid frame is accepted normally.
- **Address wrap:** A5 FF 02 AA BB EC → writes (0xFF,0xAA), (0x00,0xBB).
- **Timeout:** A5 10 then silence → `frame_err` code 3 exactly TIMEOUT_CYCLES after the 0x10 strobe. A byte injected on that exact cycle instead → no error, frame continues.
- **Backpressure, drops and reset:**
  - Good frame with `wr_ready` toggling 1-0-0-1 → `wr_addr`/`wr_data` stable while stalled, all writes in order.
  - Bytes A5 sent during COMMIT → `rx_drop` pulses and no new frame starts.
  - `rst_n` pulsed low mid-PAYLOAD → all outputs 0, no writes, next frame accepted.
